// File: rtl/reg_file_pkg.sv
// +-----------------------------------------------------------------+
// | reg_file_pkg : shared widths and types for the integer reg file |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package reg_file_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // x0 never produces a bit, so callers can OR/mask without special-casing it
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input reg_addr_t idx);
    reg_onehot = '0;
    if (en && idx != '0) reg_onehot[idx] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_if.sv
// +-----------------------------------------------------------------+
// | reg_file_if : decode <-> register file read/issue/writeback bus |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

interface reg_file_if;
  import reg_file_pkg::*;

  logic      read_en;
  reg_addr_t rs1;
  reg_addr_t rs2;
  logic      hazard;
  xlen_t     rs1_data;
  xlen_t     rs2_data;
  logic      data_valid;
  logic      issue_en;
  reg_addr_t issue_rd;
  logic      wb_en;
  reg_addr_t wb_rd;
  xlen_t     wb_data;

  modport master (
    output read_en, rs1, rs2, issue_en, issue_rd, wb_en, wb_rd, wb_data,
    input  hazard, rs1_data, rs2_data, data_valid
  );

  modport slave (
    input  read_en, rs1, rs2, issue_en, issue_rd, wb_en, wb_rd, wb_data,
    output hazard, rs1_data, rs2_data, data_valid
  );

endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// +-----------------------------------------------------------------+
// | reg_scoreboard : busy bits for issued-but-unwritten registers   |
// | Option: REG_FILE_BYPASS_EN masks the writeback target. Rev 1.0  |
// +-----------------------------------------------------------------+
`default_nettype none

module reg_scoreboard
  import reg_file_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_en_i,
  input  reg_addr_t           issue_rd_i,
  input  logic                wb_en_i,
  input  reg_addr_t           wb_rd_i,
  output logic [NUM_REGS-1:0] busy_eff_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] wb_hot;
  logic [NUM_REGS-1:0] issue_hot;

  assign wb_hot    = reg_onehot(wb_en_i, wb_rd_i);
  assign issue_hot = reg_onehot(issue_en_i, issue_rd_i);

  // Set applied after clear so a same-cycle issue to the writeback target stays busy
  always_comb begin
    busy_d = (busy_q & ~wb_hot) | issue_hot;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign busy_eff_o = busy_q & ~wb_hot;
`else
  assign busy_eff_o = busy_q;
`endif

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// +-----------------------------------------------------------------+
// | reg_file : integer register file, 2 read / 1 write, busy bits   |
// | Option: REG_FILE_BYPASS_EN write-to-read forwarding. Rev 1.0    |
// +-----------------------------------------------------------------+
`default_nettype none

module reg_file
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  reg_file_if.slave bus
);

  xlen_t               regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_eff;
  xlen_t               rs1_val;
  xlen_t               rs2_val;
  xlen_t               rs1_data_q;
  xlen_t               rs2_data_q;
  logic                data_valid_q;
  logic                accept;

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en_i (bus.issue_en),
    .issue_rd_i (bus.issue_rd),
    .wb_en_i    (bus.wb_en),
    .wb_rd_i    (bus.wb_rd),
    .busy_eff_o (busy_eff)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != '0) begin
      regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_comb begin
    rs1_val = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
    rs2_val = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];
`ifdef REG_FILE_BYPASS_EN
    if (bus.wb_en && bus.wb_rd != '0 && bus.wb_rd == bus.rs1) rs1_val = bus.wb_data;
    if (bus.wb_en && bus.wb_rd != '0 && bus.wb_rd == bus.rs2) rs2_val = bus.wb_data;
`endif
  end

  assign bus.hazard = bus.read_en && (busy_eff[bus.rs1] || busy_eff[bus.rs2]);
  assign accept     = bus.read_en && !bus.hazard;

  // Operands hold their last accepted values while no read is accepted
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= accept;
      if (accept) begin
        rs1_data_q <= rs1_val;
        rs2_data_q <= rs2_val;
      end
    end
  end

  assign bus.rs1_data   = rs1_data_q;
  assign bus.rs2_data   = rs2_data_q;
  assign bus.data_valid = data_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// +-----------------------------------------------------------------+
// | tb_reg_file : directed stimulus with queued expected responses  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_reg_file;
  import reg_file_pkg::*;

  typedef struct packed {
    logic        haz;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  reg_file_if bus();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus, applied just after the rising edge
  task automatic step(input logic re, input reg_addr_t r1, input reg_addr_t r2,
                      input logic ie, input reg_addr_t ird,
                      input logic we, input reg_addr_t wrd, input xlen_t wd,
                      input logic rst);
    bus.read_en  = re;
    bus.rs1      = r1;
    bus.rs2      = r2;
    bus.issue_en = ie;
    bus.issue_rd = ird;
    bus.wb_en    = we;
    bus.wb_rd    = wrd;
    bus.wb_data  = wd;
    rst_n        = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input logic haz, input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.haz = haz;
    e.d1  = d1;
    e.d2  = d2;
    exp_q.push_back(e);
  endtask

  // Monitor: hazard checked in the request cycle, valid/data in the following cycle
  logic        armed = 1'b0;
  logic        exp_dv = 1'b0;
  logic [31:0] hold1 = '0;
  logic [31:0] hold2 = '0;
  logic [31:0] nxt1, nxt2;
  exp_t        e_mon;

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (bus.data_valid !== exp_dv) begin
        errors++;
        $display("FAIL data_valid actual %0b required %0b at %0t", bus.data_valid, exp_dv, $time);
      end
      checks++;
      if (bus.rs1_data !== hold1) begin
        errors++;
        $display("FAIL rs1_data actual %h required %h at %0t", bus.rs1_data, hold1, $time);
      end
      checks++;
      if (bus.rs2_data !== hold2) begin
        errors++;
        $display("FAIL rs2_data actual %h required %h at %0t", bus.rs2_data, hold2, $time);
      end
    end
    exp_dv = 1'b0;
    nxt1   = hold1;
    nxt2   = hold2;
    if (bus.read_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read actual read_en=1 required no pending read at %0t", $time);
      end else begin
        e_mon = exp_q.pop_front();
        if (bus.hazard !== e_mon.haz) begin
          errors++;
          $display("FAIL hazard actual %0b required %0b at %0t", bus.hazard, e_mon.haz, $time);
        end
        if (!e_mon.haz) begin
          exp_dv = 1'b1;
          nxt1   = e_mon.d1;
          nxt2   = e_mon.d2;
        end
      end
    end
    if (rst_n) begin
      exp_dv = 1'b0;
      hold1  = '0;
      hold2  = '0;
      armed  = 1'b1;
    end else begin
      hold1 = nxt1;
      hold2 = nxt2;
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, '0, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, '0, 1'b1);

    // Reset contents and x0 behaviour
    expect_read(0, 32'h0, 32'h0);
    step(1, 5, 0, 0, 0, 0, 0, '0, 1'b0);
    step(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 1'b0);
    expect_read(0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, '0, 1'b0);

    // Plain write then read on both ports
    step(0, 0, 0, 0, 0, 1, 3, 32'h12345678, 1'b0);
    expect_read(0, 32'h12345678, 32'h12345678);
    step(1, 3, 3, 0, 0, 0, 0, '0, 1'b0);

    // Busy on rs2 blocks, writeback releases
    step(0, 0, 0, 1, 7, 0, 0, '0, 1'b0);
    expect_read(1, 32'h0, 32'h0);
    step(1, 1, 7, 0, 0, 0, 0, '0, 1'b0);
    step(0, 0, 0, 0, 0, 1, 7, 32'hA5A5A5A5, 1'b0);
    expect_read(0, 32'h0, 32'hA5A5A5A5);
    step(1, 1, 7, 0, 0, 0, 0, '0, 1'b0);

    // Same-cycle writeback of a busy register being read
    step(0, 0, 0, 1, 9, 0, 0, '0, 1'b0);
`ifdef REG_FILE_BYPASS_EN
    expect_read(0, 32'h55, 32'h0);
`else
    expect_read(1, 32'h0, 32'h0);
`endif
    step(1, 9, 0, 0, 0, 1, 9, 32'h55, 1'b0);
    expect_read(0, 32'h55, 32'h0);
    step(1, 9, 0, 0, 0, 0, 0, '0, 1'b0);

    // Issue and writeback to the same register: stays busy
    step(0, 0, 0, 1, 4, 1, 4, 32'h77, 1'b0);
    expect_read(1, 32'h0, 32'h0);
    step(1, 4, 0, 0, 0, 0, 0, '0, 1'b0);
    expect_read(1, 32'h0, 32'h0);
    step(1, 0, 4, 0, 0, 0, 0, '0, 1'b0);
    step(0, 0, 0, 0, 0, 1, 4, 32'h44, 1'b0);
    expect_read(0, 32'h44, 32'h12345678);
    step(1, 4, 3, 0, 0, 0, 0, '0, 1'b0);

    // Same-cycle write to a free register
`ifdef REG_FILE_BYPASS_EN
    expect_read(0, 32'h66, 32'h66);
`else
    expect_read(0, 32'h0, 32'h0);
`endif
    step(1, 6, 6, 0, 0, 1, 6, 32'h66, 1'b0);
    expect_read(0, 32'h66, 32'h0);
    step(1, 6, 0, 0, 0, 0, 0, '0, 1'b0);

    // Reset mid-operation kills the read and clears busy/storage
    step(0, 0, 0, 0, 0, 1, 5, 32'hCAFE0005, 1'b0);
    step(0, 0, 0, 1, 2, 0, 0, '0, 1'b0);
    expect_read(0, 32'hCAFE0005, 32'hCAFE0005);
    step(1, 5, 5, 0, 0, 0, 0, '0, 1'b1);
    expect_read(0, 32'h0, 32'h0);
    step(1, 2, 5, 0, 0, 0, 0, '0, 1'b0);
    expect_read(0, 32'h0, 32'h0);
    step(1, 3, 7, 0, 0, 0, 0, '0, 1'b0);

    step(0, 0, 0, 0, 0, 0, 0, '0, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, '0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
